video_timing_gen: RTL

- Parametrised raster timing generator for the demo designs: produces hsync/vsync, data-enable, pixel coordinates, line/frame strobes and a frame counter.
- Successor to the fixed 640x480 timing in the flame top: resolution, porches, sync polarity and pixel-clock division are all parameters.
- Adds a clock-enable gate and a free-running frame counter for animation.
- Sits between the tile clock and the pixel/shader logic inside the top-level tt_um wrapper.

---
 rtl/video_timing_gen.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Parametrised raster timing generator. A pixel tick (clk divided by
//   PIX_DIV, gated by en) advances an internal next-position counter pair
//   (hn, vn). On each tick the registered outputs take that position and
//   its decoded sync / data-enable levels.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   en           advance enable; low freezes the generator
//   hsync/vsync  sync outputs, asserted level given by HSYNC_POL/VSYNC_POL
//   de           high while the presented position is in the active area
//   x, y         presented position, blanking included
//   line_start   one-clk pulse after a tick that presented x=0
//   frame_start  one-clk pulse after a tick that presented (0,0)
//   frame_cnt    number of completed frames, wraps mod 2^FRAME_W
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIX_DIV   = 1,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0]   H_ACT    = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0]   HS_BEG   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0]   V_ACT    = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0]   VS_BEG   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic             HS_ON    = (HSYNC_POL != 0);
  localparam logic             VS_ON    = (VSYNC_POL != 0);

  // Elaboration-time guard against unusable parameter sets.
  if (PIX_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || FRAME_W < 1 ||
      (2 ** X_W) < H_TOTAL || (2 ** Y_W) < V_TOTAL) begin : g_bad_params
    $error("video_timing_gen: invalid parameter set");
  end

  logic [DIV_W-1:0]   div_q, div_d;
  logic [X_W-1:0]     hn_q, hn_d;
  logic [Y_W-1:0]     vn_q, vn_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               de_q, de_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  // Set by the first tick after reset so that first (0,0) is not counted
  // as a completed frame.
  logic               started_q, started_d;

  logic tick;
  logic at_origin;

  assign tick      = en && (div_q == DIV_LAST);
  assign at_origin = (hn_q == '0) && (vn_q == '0);

  always_comb begin
    // NOTE: every _d gets a default (hold, strobes low) before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    div_d         = div_q;
    hn_d          = hn_q;
    vn_d          = vn_q;
    x_d           = x_q;
    y_d           = y_q;
    de_d          = de_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    started_d     = started_q;

    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    if (tick) begin
      x_d           = hn_q;
      y_d           = vn_q;
      de_d          = (hn_q < H_ACT) && (vn_q < V_ACT);
      hsync_d       = ((hn_q >= HS_BEG) && (hn_q < HS_END)) ? HS_ON : ~HS_ON;
      // vn only moves at end of line, so vsync is line-granular.
      vsync_d       = ((vn_q >= VS_BEG) && (vn_q < VS_END)) ? VS_ON : ~VS_ON;
      line_start_d  = (hn_q == '0);
      frame_start_d = at_origin;
      started_d     = 1'b1;
      if (at_origin && started_q) begin
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
      end

      if (hn_q == H_LAST) begin
        hn_d = '0;
        vn_d = (vn_q == V_LAST) ? '0 : vn_q + Y_W'(1);
      end else begin
        hn_d = hn_q + X_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q         <= '0;
      hn_q          <= '0;
      vn_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      started_q     <= 1'b0;
    end else begin
      div_q         <= div_d;
      hn_q          <= hn_d;
      vn_q          <= vn_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      started_q     <= started_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
